pl_hazard_scoreboard: RTL and testbench
=======================================

# pl_hazard_scoreboard

Parametrised hazard unit for the five-stage pipelined RISC-V core. It handles operand forwarding, load-use stalls and taken-branch flushes. It adds a registered multi-cycle execute FSM that holds a long-latency op (mul/div) in E for a fixed number of cycles, plus optional saturating performance counters. It sits between the pipelined datapath and the pipeline registers and drives every stall/flush/forward select.

## Interface
- `REG_AW`, 5, register-address width.
- `MC_LATENCY`, 4, total E-stage residency of a multi-cycle op in cycles; legal range ≥ 2.
- `CNT_W`, 16, performance-counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rs1_D`, `rs2_D`  in  REG_AW  D-stage source registers.
- `rs1_E`, `rs2_E`, `rd_E`  in  REG_AW  E-stage source and destination registers.
- `res_src_E`  in  2  E-stage result source; `2'b01` = load.
- `mc_start_E`  in  1  E-stage instruction is a multi-cycle op.
- `pc_src_E`  in  1  taken branch or jump resolved in E.
- `rd_M`, `rd_W`  in  REG_AW  M and W destination registers.
- `reg_wr_M`, `reg_wr_W`  in  1  M and W register-write enables.
- `stall_F`, `stall_D`, `stall_E`  out  1  hold the PC, IF/ID and ID/EX registers.
- `flush_D`, `flush_E`, `flush_M`  out  1  clear IF/ID, ID/EX and EX/MEM.
- `forwardA_src`, `forwardB_src`  out  2  `00` = register file, `10` = M result, `01` = W result.
- `mc_busy`  out  1  FSM in BUSY.
- `stall_cnt`, `flush_cnt`  out  CNT_W  performance counters.

## Operation
- Forwarding applies to operand A and to operand B using `rs2_E`:
  - select `10` when `reg_wr_M`, `rd_M == rs*_E` and `rs*_E != 0`;
  - otherwise select `01` on the same test against W;
  - otherwise select `00`.
  - M has priority over W. Register x0 is never forwarded.
- Load-use stall (`lw_stall`) is asserted when `res_src_E == 01`, `rd_E != 0` and `rd_E` equals `rs1_D` or `rs2_D`.
- Multi-cycle FSM has two states, IDLE and BUSY, with a down-counter `cnt` of width clog2(MC_LATENCY).
  - In IDLE with `mc_start_E = 1`, the unit asserts `mc_hold` and loads `cnt = MC_LATENCY-2` → BUSY.
  - In BUSY with `cnt != 0`, `mc_hold` stays asserted and `cnt` decrements.
  - In BUSY with `cnt == 0`, `mc_hold = 0` (release cycle) → IDLE.
  - `mc_start_E` is ignored while in BUSY.
- Stalls and flushes:
  - `mc_hold` forces `stall_F = stall_D = stall_E = 1` and `flush_M = 1` (a bubble goes into M).
  - Otherwise `stall_F = stall_D = lw_stall & ~pc_src_E`.
  - `flush_D = pc_src_E`.
  - `flush_E = pc_src_E | lw_stall`, and is forced to 0 while `mc_hold`.
  - A taken branch always overrides a load-use stall so the branch target is not lost.
- Outputs are combinational except `mc_busy` and the counters.
- Reset values:
  - state IDLE, `cnt = 0`, `mc_busy = 0`, counters 0;
  - stall/flush outputs then follow the inputs combinationally.
  - Reset asserted during BUSY aborts the hold immediately.

## Timing
- Forward, stall and flush outputs are valid in the same cycle as their inputs, with zero latency.
- A multi-cycle op occupies E for exactly MC_LATENCY cycles:
  - 1 IDLE-hold cycle,
  - MC_LATENCY-2 BUSY-hold cycles,
  - 1 release cycle.
- Back-to-back multi-cycle ops: the second is seen in IDLE the cycle after release and starts immediately.
- With MC_LATENCY = 2 the sequence is hold, release.
- `mc_start_E` and `pc_src_E` never come from the same instruction. If both are high in IDLE, `mc_hold` takes priority and `pc_src_E` is re-evaluated after release.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `stall_F = 1`;
  - `flush_cnt` increments on every cycle with `pc_src_E = 1`;
  - both saturate at 2^CNT_W-1 and clear on `rst`.
- `HAZARD_PERF_CNT_EN` undefined: no counter flops are generated and both outputs are tied to 0.

## Test plan
- Forwarding priority: `rs1_E = 5`, `rd_M = rd_W = 5`, both write enables 1 → `forwardA_src = 10`. With `rd_M = 0` and `rs1_E = 0` → `00`.
- Load-use: `res_src_E = 01`, `rd_E = 3`, `rs2_D = 3` → `stall_F = stall_D = flush_E = 1` for one cycle. Adding `pc_src_E = 1` → `stall_F = 0`, `flush_D = flush_E = 1`.
- Multi-cycle, MC_LATENCY = 4: pulse-hold `mc_start_E` → stalls and `flush_M` high for 3 cycles, low on the 4th. `mc_busy` is high for cycles 2–4.
- Back-to-back multi-cycle ops → two 3-cycle hold windows separated by a single release cycle.
- Assert `rst` in the middle of BUSY → `mc_busy = 0` and stalls low in the same cycle; after release a new `mc_start_E` restarts the full latency.
- With `HAZARD_PERF_CNT_EN` and CNT_W = 4: 20 stall cycles → `stall_cnt = 15` (saturated). Without the macro, both counters read 0.

Source files
------------

// File: rtl/pl_hazard_scoreboard.sv
// Hazard unit for the five-stage core: forwarding, load-use stall, branch flush and a
// multi-cycle execute hold FSM. Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters.
module pl_hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic [1:0]        res_src_E,
    input  logic              mc_start_E,
    input  logic              pc_src_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_wr_M,
    input  logic              reg_wr_W,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic [1:0]        forwardA_src,
    output logic [1:0]        forwardB_src,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LATENCY - 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mc_hold;
    logic            lw_stall;

    always_comb begin
        forwardA_src = 2'b00;
        if (reg_wr_M && (rd_M == rs1_E) && (rs1_E != '0))
            forwardA_src = 2'b10;
        else if (reg_wr_W && (rd_W == rs1_E) && (rs1_E != '0))
            forwardA_src = 2'b01;
    end

    always_comb begin
        forwardB_src = 2'b00;
        if (reg_wr_M && (rd_M == rs2_E) && (rs2_E != '0))
            forwardB_src = 2'b10;
        else if (reg_wr_W && (rd_W == rs2_E) && (rs2_E != '0))
            forwardB_src = 2'b01;
    end

    assign lw_stall = (res_src_E == 2'b01) && (rd_E != '0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The release cycle is the BUSY cycle with cnt == 0; start requests are ignored there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_hold = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_start_E) begin
                    mc_hold = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mc_hold = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mc_busy = (state_q == BUSY);

    // A held multi-cycle op wins over both branches and load-use; otherwise a taken branch beats the stall.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        if (mc_hold) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            flush_M = 1'b1;
        end else begin
            stall_F = lw_stall & ~pc_src_E;
            stall_D = lw_stall & ~pc_src_E;
            flush_D = pc_src_E;
            flush_E = pc_src_E | lw_stall;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_F && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (pc_src_E && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pl_hazard_scoreboard.sv
// Directed bench for pl_hazard_scoreboard: expected outputs queued per step, popped and checked mid-cycle.
module tb_pl_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic [1:0]        res_src_E;
    logic              mc_start_E, pc_src_E, reg_wr_M, reg_wr_W;
    logic              stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mc_busy;
    logic [1:0]        forwardA_src, forwardB_src;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, fwdA[1:0], fwdB[1:0], mc_busy}
    logic [10:0] sb_q[$];

    pl_hazard_scoreboard #(.REG_AW(REG_AW), .MC_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .res_src_E(res_src_E), .mc_start_E(mc_start_E), .pc_src_E(pc_src_E),
        .rd_M(rd_M), .rd_W(rd_W), .reg_wr_M(reg_wr_M), .reg_wr_W(reg_wr_W),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .forwardA_src(forwardA_src), .forwardB_src(forwardB_src),
        .mc_busy(mc_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0;
        rd_M = '0; rd_W = '0; res_src_E = 2'b00;
        mc_start_E = 1'b0; pc_src_E = 1'b0; reg_wr_M = 1'b0; reg_wr_W = 1'b0;
    endtask

    task automatic expect_outs(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        logic [10:0] want;
        sb_q.push_back(exp);
        #1;
        got  = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
                forwardA_src, forwardB_src, mc_busy};
        want = sb_q.pop_front();
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic expect_cnt(input string tag, input logic [CNT_W-1:0] got,
                              input logic [CNT_W-1:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    localparam logic [10:0] IDLE0 = 11'b000000_00_00_0;
    localparam logic [10:0] HOLD0 = 11'b111001_00_00_0;
    localparam logic [10:0] HOLD1 = 11'b111001_00_00_1;
    localparam logic [10:0] REL1  = 11'b000000_00_00_1;

    initial begin
        rst = 1'b1;
        clear_inputs();

        @(negedge clk);
        expect_outs("reset", IDLE0);
        expect_cnt("reset_stall_cnt", stall_cnt, '0);
        expect_cnt("reset_flush_cnt", flush_cnt, '0);
        rst = 1'b0;

        @(negedge clk);
        rs1_E = 5; rd_M = 5; rd_W = 5; reg_wr_M = 1; reg_wr_W = 1;
        expect_outs("fwd_m_priority", 11'b000000_10_00_0);

        @(negedge clk);
        reg_wr_M = 0; rs2_E = 5;
        expect_outs("fwd_w_only", 11'b000000_01_01_0);

        @(negedge clk);
        rs1_E = 0; rd_M = 0; reg_wr_M = 1; rs2_E = 7; rd_W = 7;
        expect_outs("fwd_x0_and_b_w", 11'b000000_00_01_0);

        @(negedge clk);
        clear_inputs();
        res_src_E = 2'b01; rd_E = 3; rs2_D = 3;
        expect_outs("load_use", 11'b110010_00_00_0);

        @(negedge clk);
        res_src_E = 2'b00;
        expect_outs("no_load_no_stall", IDLE0);

        @(negedge clk);
        res_src_E = 2'b01; rd_E = 0; rs2_D = 0;
        expect_outs("load_x0_no_stall", IDLE0);

        @(negedge clk);
        rd_E = 3; rs1_D = 3; pc_src_E = 1;
        expect_outs("branch_beats_lw", 11'b000110_00_00_0);

        @(negedge clk);
        clear_inputs();
        pc_src_E = 1;
        expect_outs("branch_only", 11'b000110_00_00_0);

        // single multi-cycle op: 3 hold cycles, release, idle
        @(negedge clk);
        clear_inputs();
        mc_start_E = 1;
        expect_outs("mc_c1", HOLD0);
        @(negedge clk);
        mc_start_E = 0;
        expect_outs("mc_c2", HOLD1);
        @(negedge clk);
        expect_outs("mc_c3", HOLD1);
        @(negedge clk);
        expect_outs("mc_c4_release", REL1);
        @(negedge clk);
        expect_outs("mc_after", IDLE0);

        // back-to-back ops with start held high
        @(negedge clk);
        mc_start_E = 1;
        expect_outs("b2b_a1", HOLD0);
        @(negedge clk);
        expect_outs("b2b_a2", HOLD1);
        @(negedge clk);
        expect_outs("b2b_a3", HOLD1);
        @(negedge clk);
        expect_outs("b2b_rel", REL1);
        @(negedge clk);
        expect_outs("b2b_b1", HOLD0);
        @(negedge clk);
        expect_outs("b2b_b2", HOLD1);
        @(negedge clk);
        mc_start_E = 0;
        expect_outs("b2b_b3", HOLD1);
        @(negedge clk);
        expect_outs("b2b_rel2", REL1);
        @(negedge clk);
        expect_outs("b2b_idle", IDLE0);
`ifdef HAZARD_PERF_CNT_EN
        expect_cnt("stall_cnt_mid", stall_cnt, 4'd10);
        expect_cnt("flush_cnt_mid", flush_cnt, 4'd2);
`else
        expect_cnt("stall_cnt_off", stall_cnt, '0);
        expect_cnt("flush_cnt_off", flush_cnt, '0);
`endif

        // reset in the middle of BUSY
        @(negedge clk);
        mc_start_E = 1;
        expect_outs("rst_mc_c1", HOLD0);
        @(negedge clk);
        mc_start_E = 0;
        expect_outs("rst_mc_c2", HOLD1);
        @(negedge clk);
        rst = 1'b1;
        expect_outs("rst_abort", IDLE0);
        expect_cnt("rst_clr_stall_cnt", stall_cnt, '0);
        @(negedge clk);
        rst = 1'b0;
        mc_start_E = 1;
        expect_outs("restart_c1", HOLD0);
        @(negedge clk);
        mc_start_E = 0;
        expect_outs("restart_c2", HOLD1);
        @(negedge clk);
        expect_outs("restart_c3", HOLD1);
        @(negedge clk);
        expect_outs("restart_rel", REL1);
        @(negedge clk);
        expect_outs("restart_idle", IDLE0);

        // 3 stall cycles so far since reset; 17 more load-use cycles reach 20
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            res_src_E = 2'b01; rd_E = 9; rs1_D = 9;
        end
        @(negedge clk);
        clear_inputs();
        pc_src_E = 1;
        expect_outs("post_sat_branch", 11'b000110_00_00_0);
        @(negedge clk);
        clear_inputs();
        expect_outs("final_idle", IDLE0);
`ifdef HAZARD_PERF_CNT_EN
        expect_cnt("stall_cnt_sat", stall_cnt, 4'd15);
        expect_cnt("flush_cnt_one", flush_cnt, 4'd1);
`else
        expect_cnt("stall_cnt_off_end", stall_cnt, '0);
        expect_cnt("flush_cnt_off_end", flush_cnt, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
